noc_link_tx: RTL and testbench

//  Drain side of a router output queue: pops 64-bit flits from a circular flit queue
//  (first-word-fall-through: head flit valid on q_dout while !q_empty) and sends them

---
 rtl/noc_pkg.sv | 26 ++
 rtl/credit_counter.sv | 42 ++++
 rtl/noc_link_tx.sv | 109 ++++++++++
 tb/tb_noc_link_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit format constants and link-side FSM state type.
//   FLIT_W           flit width in bits
//   FLIT_TYPE_HI/LO  flit type field position
//   FLIT_HEAD        type code of a head flit
//   LEN_HI/LO/W      body-length field of a head flit
//   tx_state_t       transmit framing FSM states
package noc_pkg;

    localparam int unsigned FLIT_W       = 64;
    localparam int unsigned FLIT_TYPE_HI = 63;
    localparam int unsigned FLIT_TYPE_LO = 62;
    localparam logic [1:0]  FLIT_HEAD    = 2'b01;
    localparam int unsigned LEN_HI       = 4;
    localparam int unsigned LEN_LO       = 0;
    localparam int unsigned LEN_W        = LEN_HI - LEN_LO + 1;

    typedef enum logic {
        IDLE,
        BODY
    } tx_state_t;

    function automatic logic is_head(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_TYPE_HI:FLIT_TYPE_LO] == FLIT_HEAD;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// credit_counter: saturating credit pool for a credit-flow-controlled link.
// Shared by the transmit and receive sides of a link.
//   clk       in   clock
//   reset     in   asynchronous active-low reset; count returns to CREDITS
//   inc       in   one credit returned
//   dec       in   one credit consumed (caller guarantees count != 0)
//   count     out  credits currently held
//   overflow  out  registered pulse: inc arrived at CREDITS with no dec
module credit_counter #(
    parameter int unsigned CREDITS = 32,
    parameter int unsigned CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [CW-1:0] MAX = CW'(CREDITS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= MAX;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            // inc and dec together cancel; count is left untouched.
            if (inc && !dec) begin
                if (count == MAX) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (dec && !inc) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_link_tx.sv
// noc_link_tx: drains a first-word-fall-through router output queue onto a
// credit-flow-controlled link, framing packets from the head-flit length field
// and discarding stray non-head flits.
//   clk         in   clock
//   reset       in   asynchronous active-low reset
//   q_empty     in   upstream queue empty
//   q_dout      in   upstream queue head flit
//   q_rd        out  pop upstream queue (combinational)
//   tx_valid    out  tx_data valid (registered)
//   tx_data     out  transmitted flit, holds when tx_valid=0
//   tx_sop      out  first flit of packet
//   tx_eop      out  last flit of packet
//   credit_in   in   downstream freed one slot
//   credit_cnt  out  credits currently held
//   err_pkt     out  pulse: stray non-head flit dropped
//   err_credit  out  pulse: credit returned while already full
module noc_link_tx
    import noc_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned CREDITS = 32,
    parameter int unsigned CW      = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_empty,
    input  logic [WIDTH-1:0] q_dout,
    output logic             q_rd,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_sop,
    output logic             tx_eop,
    input  logic             credit_in,
    output logic [CW-1:0]    credit_cnt,
    output logic             err_pkt,
    output logic             err_credit
);

    tx_state_t        state;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] head_len;
    logic             send;
    logic             drop;

    assign head_len = q_dout[LEN_HI:LEN_LO];

    // Only the first flit of a packet is decoded; anything else seen while
    // waiting for a head is discarded without consuming a credit.
    assign drop = !q_empty && (state == IDLE) && !is_head(FLIT_W'(q_dout));
    assign send = !q_empty && (credit_cnt != '0) && !drop;
    assign q_rd = send | drop;

    credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (credit_in),
        .dec      (send),
        .count    (credit_cnt),
        .overflow (err_credit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            tx_sop    <= 1'b0;
            tx_eop    <= 1'b0;
            err_pkt   <= 1'b0;
        end else begin
            tx_valid <= send;
            err_pkt  <= drop;
            if (send) begin
                tx_data <= q_dout;
                unique case (state)
                    IDLE: begin
                        tx_sop <= 1'b1;
                        if (head_len == '0) begin
                            tx_eop <= 1'b1;
                        end else begin
                            tx_eop    <= 1'b0;
                            remaining <= head_len;
                            state     <= BODY;
                        end
                    end
                    BODY: begin
                        tx_sop    <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            tx_eop <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            tx_eop <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                tx_sop <= 1'b0;
                tx_eop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_link_tx.sv
// tb_noc_link_tx: directed bench for noc_link_tx with a behavioural upstream
// queue and a scoreboard of expected transmitted flits.
module tb_noc_link_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        q_empty = 1'b1;
    logic [63:0] q_dout = '0;
    logic        q_rd;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic        credit_in = 1'b0;
    logic [5:0]  credit_cnt;
    logic        err_pkt;
    logic        err_credit;

    int tests = 0;
    int fails = 0;
    int n_tx  = 0;

    logic [63:0] fifo[$];
    logic [65:0] exp_q[$];   // {sop, eop, data}

    noc_link_tx dut (
        .clk        (clk),
        .reset      (reset),
        .q_empty    (q_empty),
        .q_dout     (q_dout),
        .q_rd       (q_rd),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_sop     (tx_sop),
        .tx_eop     (tx_eop),
        .credit_in  (credit_in),
        .credit_cnt (credit_cnt),
        .err_pkt    (err_pkt),
        .err_credit (err_credit)
    );

    always #5 clk = ~clk;

    // Behavioural FWFT upstream queue; outputs updated with NBAs so the DUT
    // samples the pre-edge head flit.
    always @(posedge clk) begin
        if (q_rd && fifo.size() != 0) void'(fifo.pop_front());
        q_empty <= (fifo.size() == 0);
        q_dout  <= (fifo.size() != 0) ? fifo[0] : 64'd0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && tx_valid) begin
            logic [65:0] e;
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_tx observed=%h expected=none", tx_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tx_data", tx_data, e[63:0]);
                chk("tx_sop", 64'(tx_sop), 64'(e[65]));
                chk("tx_eop", 64'(tx_eop), 64'(e[64]));
            end
            n_tx++;
        end
    end

    function automatic logic [63:0] head(input int id, input int len);
        return {2'b01, 38'd0, 8'(id), 11'd0, 5'(len)};
    endfunction

    function automatic logic [63:0] body(input int id);
        return {2'b10, 54'd0, 8'(id)};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [63:0] f, input logic sends, input logic sop,
                        input logic eop);
        fifo.push_back(f);
        if (sends) exp_q.push_back({sop, eop, f});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;

        // 1: reset state
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_q_rd", 64'(q_rd), 64'd0);
        chk("rst_credit", 64'(credit_cnt), 64'd32);
        chk("rst_err_pkt", 64'(err_pkt), 64'd0);
        chk("rst_err_credit", 64'(err_credit), 64'd0);

        // 2: head LEN=2 plus two bodies
        push(head(1, 2), 1'b1, 1'b1, 1'b0);
        push(body(2), 1'b1, 1'b0, 1'b0);
        push(body(3), 1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_q_rd_high", 64'(q_rd), 64'd1);
            tick();
        end
        chk("t2_q_rd_low", 64'(q_rd), 64'd0);
        chk("t2_credit", 64'(credit_cnt), 64'd29);
        drain("t2_drain");

        // 3: two single-flit packets
        push(head(4, 0), 1'b1, 1'b1, 1'b1);
        push(head(5, 0), 1'b1, 1'b1, 1'b1);
        drain("t3_drain");
        chk("t3_credit", 64'(credit_cnt), 64'd27);

        // 4: stray body flit while idle
        push(64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t4_q_rd", 64'(q_rd), 64'd1);
        tick();
        chk("t4_err_pkt", 64'(err_pkt), 64'd1);
        chk("t4_tx_valid", 64'(tx_valid), 64'd0);
        tick();
        chk("t4_err_pkt_clr", 64'(err_pkt), 64'd0);
        chk("t4_credit", 64'(credit_cnt), 64'd27);

        // 5: credit exhaustion; first top the pool back up to 32
        for (int i = 0; i < 5; i++) begin
            credit_in = 1'b1;
            tick();
        end
        credit_in = 1'b0;
        tick();
        chk("t5_refill", 64'(credit_cnt), 64'd32);
        base = n_tx;
        for (int i = 0; i < 40; i++) push(head(16 + i, 0), 1'b1, 1'b1, 1'b1);
        repeat (45) tick();
        chk("t5_sent32", 64'(n_tx - base), 64'd32);
        chk("t5_credit0", 64'(credit_cnt), 64'd0);
        chk("t5_q_rd_stall", 64'(q_rd), 64'd0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("t5_one_credit", 64'(credit_cnt), 64'd1);
        tick();
        tick();
        chk("t5_sent33", 64'(n_tx - base), 64'd33);
        chk("t5_credit0b", 64'(credit_cnt), 64'd0);
        credit_in = 1'b1;
        tick();
        chk("t5_q_rd_ready", 64'(q_rd), 64'd1);
        tick();   // send and credit_in in the same cycle
        credit_in = 1'b0;
        chk("t5_same_cycle", 64'(credit_cnt), 64'd1);
        for (int i = 0; i < 37; i++) begin
            credit_in = 1'b1;
            tick();
            credit_in = 1'b0;
            tick();
        end
        drain("t5_drain");
        chk("t5_all_sent", 64'(n_tx - base), 64'd40);
        chk("t5_credit_full", 64'(credit_cnt), 64'd32);

        // 6: reset mid-packet
        push(head(60, 3), 1'b1, 1'b1, 1'b0);
        push(body(61), 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("t6_rst_tx_data", tx_data, 64'd0);
        chk("t6_rst_credit", 64'(credit_cnt), 64'd32);
        tick();
        reset = 1'b1;
        tick();
        push(body(62), 1'b0, 1'b0, 1'b0);
        tick();
        chk("t6_drop_q_rd", 64'(q_rd), 64'd1);
        tick();
        chk("t6_err_pkt", 64'(err_pkt), 64'd1);
        chk("t6_no_tx", 64'(tx_valid), 64'd0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("t6_err_credit", 64'(err_credit), 64'd1);
        chk("t6_credit_sat", 64'(credit_cnt), 64'd32);
        tick();
        chk("t6_err_credit_clr", 64'(err_credit), 64'd0);
        chk("t6_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
